// File: rtl/program_counter.sv
// Program counter register: a single WIDTH-bit register with a load enable and
// an asynchronous active-high reset. pc_out comes straight from the register.
module program_counter #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out
);

  logic [WIDTH-1:0] pc_q;

  // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_VALUE;
    end else if (PCWrite == 1'b1) begin
      // An unknown enable compares false, so the register holds.
      pc_q <= pc_in;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a vector table replayed through a
// scoreboard queue, plus hand-written async-reset and between-edge sequences.
module tb_program_counter;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = '1;

  logic         clk;
  logic         reset;
  logic         PCWrite;
  logic [W-1:0] pc_in;
  logic [W-1:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         rst;
    logic         we;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb_q[$];

  program_counter #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk    (clk),
    .reset  (reset),
    .PCWrite(PCWrite),
    .pc_in  (pc_in),
    .pc_out (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual time %0t, required finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input logic rst, input logic we, input logic [W-1:0] din,
                         input logic [W-1:0] exp);
    vec_t v;
    v.rst = rst; v.we = we; v.din = din; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, push the expected value, compare after the rising edge.
  task automatic run_vec(input int idx);
    logic [W-1:0] exp_val;
    @(negedge clk);
    reset   = vecs[idx].rst;
    PCWrite = vecs[idx].we;
    pc_in   = vecs[idx].din;
    sb_q.push_back(vecs[idx].exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check($sformatf("scoreboard_empty_%0d", idx), pc_out, ~pc_out);
    end else begin
      exp_val = sb_q.pop_front();
      check($sformatf("vec_%0d", idx), pc_out, exp_val);
    end
  endtask

  initial begin
    // Reset with PCWrite=0, pc_in=0: pc_out is 0 immediately, through an edge, and after release.
    reset = 1'b1; PCWrite = 1'b0; pc_in = '0;
    #1;
    check("reset_async_initial", pc_out, '0);
    @(posedge clk); #1;
    check("reset_held_edge", pc_out, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_release", pc_out, '0);

    // Table: load, hold, boundary values, reset priority over load, post-release hold.
    add_vec(1'b0, 1'b1, 64'd4,                 64'd4);
    add_vec(1'b0, 1'b1, 64'd8,                 64'd8);
    add_vec(1'b0, 1'b0, 64'd16,                64'd8);
    add_vec(1'b0, 1'b0, 64'd16,                64'd8);
    add_vec(1'b0, 1'b0, 64'd16,                64'd8);
    add_vec(1'b0, 1'b1, ONES,                  ONES);
    add_vec(1'b0, 1'b0, 64'd0,                 ONES);
    add_vec(1'b0, 1'b1, 64'd0,                 64'd0);
    add_vec(1'b0, 1'b1, 64'hA5A5_5A5A_F00D_0001, 64'hA5A5_5A5A_F00D_0001);
    add_vec(1'b0, 1'b1, 64'h8000_0000_0000_0003, 64'h8000_0000_0000_0003);
    add_vec(1'b1, 1'b1, 64'h1234,              64'd0);
    add_vec(1'b0, 1'b0, 64'h1234,              64'd0);
    add_vec(1'b0, 1'b0, 64'h5678,              64'd0);
    add_vec(1'b0, 1'b1, 64'd5,                 64'd5);
    for (int i = 0; i < vecs.size(); i++) run_vec(i);
    check("scoreboard_drained", 64'(sb_q.size()), '0);

    // Mid-operation reset raised between edges clears pc_out without a clock edge.
    @(negedge clk);
    PCWrite = 1'b1; pc_in = 64'd8;
    @(posedge clk); #1;
    check("load_8_before_reset", pc_out, 64'd8);
    @(negedge clk);
    PCWrite = 1'b0; pc_in = 64'd16;
    #2;
    reset = 1'b1;
    #1;
    check("reset_midcycle_immediate", pc_out, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_release_hold_1", pc_out, '0);
    @(posedge clk); #1;
    check("reset_release_hold_2", pc_out, '0);

    // Input changes between edges do not reach pc_out until the next rising edge.
    @(negedge clk);
    PCWrite = 1'b1; pc_in = 64'h10;
    @(posedge clk); #1;
    check("load_0x10", pc_out, 64'h10);
    pc_in = 64'h20;
    #2;
    check("pc_in_change_no_effect_1", pc_out, 64'h10);
    PCWrite = 1'b0; pc_in = 64'h25;
    #2;
    check("pcwrite_toggle_no_effect", pc_out, 64'h10);
    PCWrite = 1'b1; pc_in = 64'h30;
    #1;
    check("pc_in_change_no_effect_2", pc_out, 64'h10);
    @(posedge clk); #1;
    check("load_last_pc_in", pc_out, 64'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the bit width of pc_in and pc_out.
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits), SHALL set the value loaded into pc_out on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 PCWrite  input  1  SHALL be the load enable; 1 = load pc_in, 0 = hold.
REQ-006 pc_in  input  WIDTH  SHALL carry the next program-counter value.
REQ-007 pc_out  output  WIDTH  SHALL carry the current program-counter value, driven directly from a register.

Function
REQ-008 The block SHALL hold one WIDTH-bit register, and pc_out SHALL equal that register at all times.
REQ-009 When reset=1 is asserted, the register SHALL take RESET_VALUE immediately, with no clock edge needed.
REQ-010 While reset=1, the register SHALL hold RESET_VALUE regardless of clk, PCWrite or pc_in.
REQ-011 On a rising clk edge with reset=0 and PCWrite=1, the register SHALL load pc_in.
- Latency: 1 cycle.
- The new value SHALL be visible on pc_out right after that edge.
REQ-012 On a rising clk edge with reset=0 and PCWrite=0, the register SHALL keep its previous value.
REQ-013 pc_in SHALL be loaded verbatim: no increment, no alignment masking, no sign change.
- All 2^WIDTH values are legal, including 0 and all-ones.
REQ-014 Changes on pc_in or PCWrite between clock edges SHALL NOT affect pc_out.
- pc_out has no combinational path from any input except the asynchronous reset.
REQ-015 If reset and a load-enabled clock edge occur together, reset SHALL win and pc_out SHALL be RESET_VALUE.
REQ-016 When reset is released, pc_out SHALL stay RESET_VALUE until the first rising edge with PCWrite=1.
REQ-017 If PCWrite is not exactly 1 (0, X or Z), the register SHALL hold its value.
- Only PCWrite=1 loads.
REQ-018 The block SHALL have no other state, outputs or side effects.

Reset
REQ-019 Reset SHALL be asynchronous on assertion.
- pc_out SHALL go to RESET_VALUE within the same simulation time step that reset rises.
REQ-020 Reset SHALL be asynchronous on release.
- After release, normal operation resumes at the next rising clk edge.
REQ-021 After power-up, the register value SHALL be undefined until the first reset assertion.

Verification
REQ-022 Reset: reset=1 for one cycle, PCWrite=0, pc_in=0 -> pc_out=0 while reset is high and after release.
REQ-023 Load: reset=0, PCWrite=1, pc_in=4 -> pc_out=4 after the next rising edge.
- Then pc_in=8 -> pc_out=8 after the following edge.
REQ-024 Hold: with pc_out=8, set PCWrite=0 and pc_in=16 for several edges -> pc_out stays 8.
REQ-025 Mid-operation reset: with pc_out=8, raise reset between clock edges -> pc_out=0 immediately.
- Release reset with PCWrite=0 -> pc_out stays 0.
REQ-026 Boundary and priority:
- PCWrite=1, pc_in=all-ones -> pc_out=all-ones after one edge.
- reset=1 held through an edge with PCWrite=1, pc_in=0x1234 -> pc_out=0.
- Changing pc_in between edges -> pc_out unchanged until the next edge.
